// File: rtl/ccip_avmm_pkg.sv
// Shared CCI-P MMIO and Avalon-MM bridge types, plus the bypass-window decode helper.
package ccip_avmm_pkg;

   typedef struct packed {
      logic [15:0] address;
      logic [1:0]  length;
      logic [8:0]  tid;
   } t_ccip_c0_ReqMmioHdr;

   typedef struct packed {
      t_ccip_c0_ReqMmioHdr hdr;
      logic [63:0]         data;
      logic                mmioRdValid;
      logic                mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      logic [8:0] tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      logic [63:0]         data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      logic        is_read;
      logic        is_64;
      logic [15:0] addr;
      logic [63:0] data;
   } t_ccip_avmm_mmio_cmd;

   typedef struct packed {
      logic        hi_flag;
      logic [8:0]  tid;
      logic [31:0] age;
   } t_ccip_avmm_mmio_rd_track;

   localparam logic [63:0] CCIP_AVMM_MMIO_ERR_DATA = '1;

   // Subtraction form avoids overflow when the window ends at the top of the address space.
   function automatic logic in_bypass_window(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] size);
      return (size != 32'd0) && (addr >= base) && ((addr - base) < size);
   endfunction

endpackage

// File: rtl/ccip_avmm_sync_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head entry whenever empty is low.
module ccip_avmm_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   usedw
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];
   assign usedw   = cnt_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/ccip_avmm_mmio_v2.sv
// CCI-P MMIO to Avalon-MM master bridge with a command queue, in-order read tracking
// and timeout conversion of lost reads into all-ones responses.
module ccip_avmm_mmio_v2
   import ccip_avmm_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH         = 18,
   parameter int unsigned CMD_FIFO_DEPTH     = 16,
   parameter int unsigned MAX_OUTSTANDING_RD = 64,
   parameter int unsigned BYPASS0_ADDR       = 0,
   parameter int unsigned BYPASS0_SIZE       = 0,
   parameter int unsigned BYPASS1_ADDR       = 0,
   parameter int unsigned BYPASS1_SIZE       = 0,
   parameter int unsigned RD_TIMEOUT         = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  t_if_ccip_c0_Rx        ccip_c0_Rx_port,
   output t_if_ccip_c2_Tx        ccip_c2_Tx_port,
   output logic [ADDR_WIDTH-1:0] avmm_address,
   output logic [63:0]           avmm_writedata,
   output logic [7:0]            avmm_byteenable,
   output logic                  avmm_write,
   output logic                  avmm_read,
   input  logic                  avmm_waitrequest,
   input  logic [63:0]           avmm_readdata,
   input  logic                  avmm_readdatavalid,
   output logic                  err_cmd_overflow,
   output logic [15:0]           err_timeout_cnt
);

   localparam int unsigned CMD_W = $bits(t_ccip_avmm_mmio_cmd);
   localparam int unsigned TRK_W = 10;
   localparam int unsigned OW    = $clog2(MAX_OUTSTANDING_RD) + 1;

   logic [31:0]         c0_byte_addr;
   logic                bypass;
   logic                req_v_q, req_rd_q;
   t_ccip_c0_ReqMmioHdr req_hdr_q;
   logic [63:0]         req_data_q;
   t_ccip_avmm_mmio_cmd cmd_in, cmd_head;
   logic [CMD_W-1:0]    cmd_dout;
   logic                cmd_full, cmd_empty, cmd_push, cmd_pop, accept_ok;
   logic [TRK_W-1:0]    trk_din, trk_dout;
   logic                trk_full, trk_empty, trk_push, trk_pop;
   t_ccip_avmm_mmio_rd_track trk_head;
   logic [$clog2(CMD_FIFO_DEPTH):0]     unused_cmd_usedw;
   logic [$clog2(MAX_OUTSTANDING_RD):0] unused_trk_usedw;
   logic [OW-1:0]       issued_q;
   logic [31:0]         age_q;
   logic [15:0]         drop_q;
   logic                rd_issue, data_take, late_drop, timeout_hit, to_fire;
   logic                rsp_valid_q;
   logic [8:0]          rsp_tid_q;
   logic [63:0]         rsp_data_q;

   assign c0_byte_addr = {14'd0, ccip_c0_Rx_port.hdr.address, 2'b00};
   assign bypass = in_bypass_window(c0_byte_addr, BYPASS0_ADDR, BYPASS0_SIZE) |
                   in_bypass_window(c0_byte_addr, BYPASS1_ADDR, BYPASS1_SIZE);

   always_ff @(posedge clk) begin
      if (reset) begin
         req_v_q <= 1'b0;
      end else begin
         req_v_q <= (ccip_c0_Rx_port.mmioRdValid | ccip_c0_Rx_port.mmioWrValid) & ~bypass;
      end
      req_rd_q   <= ccip_c0_Rx_port.mmioRdValid;
      req_hdr_q  <= ccip_c0_Rx_port.hdr;
      req_data_q <= ccip_c0_Rx_port.data;
   end

   always_comb begin
      cmd_in         = '0;
      cmd_in.is_read = req_rd_q;
      cmd_in.is_64   = |req_hdr_q.length;
      cmd_in.addr    = req_hdr_q.address;
      cmd_in.data    = cmd_in.is_64 ? req_data_q : {2{req_data_q[31:0]}};
   end

   // A read that cannot get a tracker slot is treated like a command-queue overflow.
   assign accept_ok = req_v_q & ~cmd_full & ~(req_rd_q & trk_full);
   assign cmd_push  = accept_ok;
   assign trk_push  = accept_ok & req_rd_q;
   assign trk_din   = {~cmd_in.is_64 & req_hdr_q.address[0], req_hdr_q.tid};

   always_ff @(posedge clk) begin
      if (reset)                       err_cmd_overflow <= 1'b0;
      else if (req_v_q && !accept_ok)  err_cmd_overflow <= 1'b1;
   end

   ccip_avmm_sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_push),
      .din   (cmd_in),
      .pop   (cmd_pop),
      .dout  (cmd_dout),
      .full  (cmd_full),
      .empty (cmd_empty),
      .usedw (unused_cmd_usedw)
   );

   ccip_avmm_sync_fifo #(
      .WIDTH (TRK_W),
      .DEPTH (MAX_OUTSTANDING_RD)
   ) u_trk_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (trk_push),
      .din   (trk_din),
      .pop   (trk_pop),
      .dout  (trk_dout),
      .full  (trk_full),
      .empty (trk_empty),
      .usedw (unused_trk_usedw)
   );

   assign cmd_head        = t_ccip_avmm_mmio_cmd'(cmd_dout);
   assign avmm_address    = ADDR_WIDTH'({cmd_head.addr[15:1], 3'b000});
   assign avmm_writedata  = cmd_head.data;
   assign avmm_byteenable = cmd_head.is_64 ? 8'hFF : (cmd_head.addr[0] ? 8'hF0 : 8'h0F);
   assign avmm_read  = ~cmd_empty & cmd_head.is_read & (issued_q < OW'(MAX_OUTSTANDING_RD));
   assign avmm_write = ~cmd_empty & ~cmd_head.is_read;
   assign cmd_pop    = (avmm_read | avmm_write) & ~avmm_waitrequest;
   assign rd_issue   = avmm_read & ~avmm_waitrequest;

   assign trk_head = '{hi_flag: trk_dout[9], tid: trk_dout[8:0], age: age_q};

   // issued_q counts tracker entries whose read is on the bus; the head is the oldest of them.
   assign data_take   = avmm_readdatavalid & (drop_q == 16'd0) & (issued_q != '0) & ~trk_empty;
   assign late_drop   = avmm_readdatavalid & (drop_q != 16'd0);
   assign timeout_hit = (RD_TIMEOUT != 0) && (issued_q != '0) && (trk_head.age == RD_TIMEOUT);
   assign to_fire     = timeout_hit & ~data_take;
   assign trk_pop     = data_take | to_fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         issued_q        <= '0;
         age_q           <= '0;
         drop_q          <= '0;
         err_timeout_cnt <= '0;
         rsp_valid_q     <= 1'b0;
      end else begin
         issued_q    <= issued_q + OW'(rd_issue) - OW'(trk_pop);
         drop_q      <= drop_q - 16'(late_drop) + 16'(to_fire);
         rsp_valid_q <= trk_pop;
         if (trk_pop)                age_q <= '0;
         else if (issued_q != '0)    age_q <= age_q + 32'd1;
         if (to_fire && err_timeout_cnt != 16'hFFFF) err_timeout_cnt <= err_timeout_cnt + 16'd1;
      end
      rsp_tid_q  <= trk_head.tid;
      rsp_data_q <= to_fire ? CCIP_AVMM_MMIO_ERR_DATA :
                    {avmm_readdata[63:32],
                     trk_head.hi_flag ? avmm_readdata[63:32] : avmm_readdata[31:0]};
   end

   always_comb begin
      ccip_c2_Tx_port             = '0;
      ccip_c2_Tx_port.hdr.tid     = rsp_tid_q;
      ccip_c2_Tx_port.mmioRdValid = rsp_valid_q;
      ccip_c2_Tx_port.data        = rsp_data_q;
   end

endmodule

// File: tb/tb_ccip_avmm_mmio_v2.sv
// Directed bench for ccip_avmm_mmio_v2: one bypass window, short timeout, 4-entry command queue.
module tb_ccip_avmm_mmio_v2;
   import ccip_avmm_pkg::*;

   logic           clk = 1'b0;
   logic           reset;
   t_if_ccip_c0_Rx c0;
   t_if_ccip_c2_Tx c2;
   logic [17:0]    avmm_address;
   logic [63:0]    avmm_writedata;
   logic [7:0]     avmm_byteenable;
   logic           avmm_write, avmm_read;
   logic           avmm_waitrequest;
   logic [63:0]    avmm_readdata;
   logic           avmm_readdatavalid;
   logic           err_cmd_overflow;
   logic [15:0]    err_timeout_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ccip_avmm_mmio_v2 #(
      .ADDR_WIDTH         (18),
      .CMD_FIFO_DEPTH     (4),
      .MAX_OUTSTANDING_RD (64),
      .BYPASS0_ADDR       (32'h1000),
      .BYPASS0_SIZE       (32'h100),
      .BYPASS1_ADDR       (0),
      .BYPASS1_SIZE       (0),
      .RD_TIMEOUT         (16)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .ccip_c0_Rx_port    (c0),
      .ccip_c2_Tx_port    (c2),
      .avmm_address       (avmm_address),
      .avmm_writedata     (avmm_writedata),
      .avmm_byteenable    (avmm_byteenable),
      .avmm_write         (avmm_write),
      .avmm_read          (avmm_read),
      .avmm_waitrequest   (avmm_waitrequest),
      .avmm_readdata      (avmm_readdata),
      .avmm_readdatavalid (avmm_readdatavalid),
      .err_cmd_overflow   (err_cmd_overflow),
      .err_timeout_cnt    (err_timeout_cnt)
   );

   // All tasks start and end on a negedge; inputs change and outputs are sampled there.
   task automatic send_mmio(input logic rd, input logic [15:0] addr, input logic [1:0] len,
                            input logic [8:0] tid, input logic [63:0] data);
      c0.hdr.address  = addr;
      c0.hdr.length   = len;
      c0.hdr.tid      = tid;
      c0.data         = data;
      c0.mmioRdValid  = rd;
      c0.mmioWrValid  = ~rd;
      @(negedge clk);
      c0.mmioRdValid  = 1'b0;
      c0.mmioWrValid  = 1'b0;
   endtask

   task automatic wait_read(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (avmm_read) seen = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic give_data(input logic [63:0] d);
      avmm_readdata      = d;
      avmm_readdatavalid = 1'b1;
      @(negedge clk);
      avmm_readdatavalid = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      do_reset();
      n_tests++; if (avmm_read !== 1'b0) begin n_fail++;
         $display("FAIL reset_read got=%b exp=0", avmm_read); end
      n_tests++; if (avmm_write !== 1'b0) begin n_fail++;
         $display("FAIL reset_write got=%b exp=0", avmm_write); end
      n_tests++; if (c2.mmioRdValid !== 1'b0) begin n_fail++;
         $display("FAIL reset_c2_valid got=%b exp=0", c2.mmioRdValid); end
      n_tests++; if (err_cmd_overflow !== 1'b0) begin n_fail++;
         $display("FAIL reset_overflow got=%b exp=0", err_cmd_overflow); end
      n_tests++; if (err_timeout_cnt !== 16'd0) begin n_fail++;
         $display("FAIL reset_timeout_cnt got=%0d exp=0", err_timeout_cnt); end
   endtask

   task automatic test_read64;
      bit seen;
      send_mmio(1'b1, 16'h0010, 2'b01, 9'h1A, 64'd0);
      wait_read(seen);
      n_tests++; if (!seen) begin n_fail++; $display("FAIL rd64_issue got=none exp=read"); end
      n_tests++; if (avmm_address !== 18'h40) begin n_fail++;
         $display("FAIL rd64_addr got=%h exp=40", avmm_address); end
      n_tests++; if (avmm_byteenable !== 8'hFF) begin n_fail++;
         $display("FAIL rd64_be got=%h exp=ff", avmm_byteenable); end
      repeat (3) @(negedge clk);
      n_tests++; if (c2.mmioRdValid !== 1'b0) begin n_fail++;
         $display("FAIL rd64_early_rsp got=%b exp=0", c2.mmioRdValid); end
      give_data(64'h1122334455667788);
      n_tests++; if (c2.mmioRdValid !== 1'b1 || c2.hdr.tid !== 9'h1A) begin n_fail++;
         $display("FAIL rd64_rsp got=v%b tid%h exp=v1 tid1a", c2.mmioRdValid, c2.hdr.tid); end
      n_tests++; if (c2.data !== 64'h1122334455667788) begin n_fail++;
         $display("FAIL rd64_data got=%h exp=1122334455667788", c2.data); end
   endtask

   task automatic test_read32_hi;
      bit seen;
      send_mmio(1'b1, 16'h0005, 2'b00, 9'h05, 64'd0);
      wait_read(seen);
      n_tests++; if (!seen || avmm_address !== 18'h10 || avmm_byteenable !== 8'hF0) begin
         n_fail++;
         $display("FAIL rd32_issue got=seen%b a%h be%h exp=seen1 a10 bef0",
                  seen, avmm_address, avmm_byteenable); end
      @(negedge clk);
      give_data(64'hAAAABBBBCCCCDDDD);
      n_tests++; if (c2.mmioRdValid !== 1'b1 || c2.hdr.tid !== 9'h05) begin n_fail++;
         $display("FAIL rd32_rsp got=v%b tid%h exp=v1 tid05", c2.mmioRdValid, c2.hdr.tid); end
      n_tests++; if (c2.data !== 64'hAAAABBBBAAAABBBB) begin n_fail++;
         $display("FAIL rd32_data got=%h exp=aaaabbbbaaaabbbb", c2.data); end
   endtask

   task automatic test_write32;
      bit seen = 1'b0;
      send_mmio(1'b0, 16'h0003, 2'b00, 9'h0, 64'h12345678DEADBEEF);
      for (int i = 0; i < 10 && !seen; i++) begin
         if (avmm_write) seen = 1'b1;
         else @(negedge clk);
      end
      n_tests++; if (!seen || avmm_address !== 18'h08 || avmm_byteenable !== 8'hF0) begin
         n_fail++;
         $display("FAIL wr32_issue got=seen%b a%h be%h exp=seen1 a08 bef0",
                  seen, avmm_address, avmm_byteenable); end
      n_tests++; if (avmm_writedata !== 64'hDEADBEEFDEADBEEF) begin n_fail++;
         $display("FAIL wr32_data got=%h exp=deadbeefdeadbeef", avmm_writedata); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [17:0] ga [8];
      logic [63:0] gd [8];
      int n = 0;
      avmm_waitrequest = 1'b1;
      send_mmio(1'b0, 16'h0008, 2'b01, 9'h0, 64'hA0A0_0000_0000_0001);
      send_mmio(1'b0, 16'h0010, 2'b01, 9'h0, 64'hA0A0_0000_0000_0002);
      send_mmio(1'b0, 16'h0018, 2'b01, 9'h0, 64'hA0A0_0000_0000_0003);
      repeat (5) @(negedge clk);
      n_tests++; if (avmm_write !== 1'b1 || avmm_address !== 18'h20) begin n_fail++;
         $display("FAIL b2b_stall got=w%b a%h exp=w1 a20", avmm_write, avmm_address); end
      avmm_waitrequest = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (avmm_write && n < 8) begin ga[n] = avmm_address; gd[n] = avmm_writedata; n++; end
         @(negedge clk);
      end
      n_tests++; if (n !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", n); end
      for (int i = 0; i < 3 && i < n; i++) begin
         n_tests++;
         if (ga[i] !== 18'(32'h20 * (i + 1)) || gd[i] !== (64'hA0A0_0000_0000_0000 + 64'(i + 1)))
         begin n_fail++;
            $display("FAIL b2b_wr%0d got=a%h d%h exp=a%h d%h", i, ga[i], gd[i],
                     18'(32'h20 * (i + 1)), 64'hA0A0_0000_0000_0000 + 64'(i + 1)); end
      end
      n_tests++; if (err_cmd_overflow !== 1'b0) begin n_fail++;
         $display("FAIL b2b_overflow got=%b exp=0", err_cmd_overflow); end
   endtask

   task automatic test_bypass;
      int nrd = 0, nrsp = 0;
      bit seen;
      send_mmio(1'b1, 16'h0400, 2'b01, 9'h21, 64'd0);
      for (int i = 0; i < 10; i++) begin
         if (avmm_read) nrd++;
         if (c2.mmioRdValid) nrsp++;
         @(negedge clk);
      end
      n_tests++; if (nrd !== 0 || nrsp !== 0) begin n_fail++;
         $display("FAIL bypass_ignored got=rd%0d rsp%0d exp=rd0 rsp0", nrd, nrsp); end
      send_mmio(1'b1, 16'h0440, 2'b01, 9'h22, 64'd0);
      wait_read(seen);
      n_tests++; if (!seen || avmm_address !== 18'h1100) begin n_fail++;
         $display("FAIL bypass_outside_addr got=seen%b a%h exp=seen1 a1100", seen, avmm_address);
      end
      @(negedge clk);
      give_data(64'h0102030405060708);
      n_tests++; if (c2.mmioRdValid !== 1'b1 || c2.hdr.tid !== 9'h22 ||
                     c2.data !== 64'h0102030405060708) begin n_fail++;
         $display("FAIL bypass_outside_rsp got=v%b tid%h d%h exp=v1 tid22 d0102030405060708",
                  c2.mmioRdValid, c2.hdr.tid, c2.data); end
   endtask

   task automatic test_timeout;
      bit seen;
      bit got = 1'b0;
      int cnt = 0;
      int nrsp = 0;
      send_mmio(1'b1, 16'h0020, 2'b01, 9'h33, 64'd0);
      wait_read(seen);
      n_tests++; if (!seen) begin n_fail++; $display("FAIL to_issue got=none exp=read"); end
      // Handshake edge, then 16 edges of age counting, then the registered response: 18 negedges.
      while (cnt < 40 && !got) begin
         @(negedge clk);
         cnt++;
         if (c2.mmioRdValid) got = 1'b1;
      end
      n_tests++; if (!got || cnt !== 18) begin n_fail++;
         $display("FAIL to_latency got=seen%b cyc%0d exp=seen1 cyc18", got, cnt); end
      n_tests++; if (c2.data !== 64'hFFFF_FFFF_FFFF_FFFF || c2.hdr.tid !== 9'h33) begin n_fail++;
         $display("FAIL to_rsp got=d%h tid%h exp=dffffffffffffffff tid33", c2.data, c2.hdr.tid);
      end
      n_tests++; if (err_timeout_cnt !== 16'd1) begin n_fail++;
         $display("FAIL to_cnt got=%0d exp=1", err_timeout_cnt); end
      give_data(64'hBAD0BAD0BAD0BAD0);
      for (int i = 0; i < 3; i++) begin
         if (c2.mmioRdValid) nrsp++;
         @(negedge clk);
      end
      n_tests++; if (nrsp !== 0) begin n_fail++;
         $display("FAIL to_late_drop got=%0d rsp exp=0", nrsp); end
      send_mmio(1'b1, 16'h0024, 2'b01, 9'h34, 64'd0);
      wait_read(seen);
      @(negedge clk);
      give_data(64'h5555666677778888);
      n_tests++; if (c2.mmioRdValid !== 1'b1 || c2.hdr.tid !== 9'h34 ||
                     c2.data !== 64'h5555666677778888) begin n_fail++;
         $display("FAIL to_next_rd got=v%b tid%h d%h exp=v1 tid34 d5555666677778888",
                  c2.mmioRdValid, c2.hdr.tid, c2.data); end
   endtask

   task automatic test_overflow;
      logic [17:0] ga [8];
      int n = 0;
      avmm_waitrequest = 1'b1;
      for (int i = 0; i < 6; i++) send_mmio(1'b0, 16'(16'h0100 + 2 * i), 2'b01, 9'h0, 64'(i));
      repeat (2) @(negedge clk);
      n_tests++; if (err_cmd_overflow !== 1'b1) begin n_fail++;
         $display("FAIL ovf_flag got=%b exp=1", err_cmd_overflow); end
      avmm_waitrequest = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (avmm_write && n < 8) begin ga[n] = avmm_address; n++; end
         @(negedge clk);
      end
      n_tests++; if (n !== 4) begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", n); end
      for (int i = 0; i < 4 && i < n; i++) begin
         n_tests++; if (ga[i] !== 18'(32'h400 + 8 * i)) begin n_fail++;
            $display("FAIL ovf_wr%0d got=%h exp=%h", i, ga[i], 18'(32'h400 + 8 * i)); end
      end
      n_tests++; if (err_cmd_overflow !== 1'b1) begin n_fail++;
         $display("FAIL ovf_sticky got=%b exp=1", err_cmd_overflow); end
   endtask

   task automatic test_reset_clears;
      do_reset();
      n_tests++; if (err_cmd_overflow !== 1'b0 || err_timeout_cnt !== 16'd0) begin n_fail++;
         $display("FAIL rst_clear got=ovf%b to%0d exp=ovf0 to0", err_cmd_overflow,
                  err_timeout_cnt); end
   endtask

   initial begin
      c0                 = '0;
      reset              = 1'b1;
      avmm_waitrequest   = 1'b0;
      avmm_readdata      = '0;
      avmm_readdatavalid = 1'b0;
      @(negedge clk);
      test_reset();
      test_read64();
      test_read32_hi();
      test_write32();
      test_back_to_back();
      test_bypass();
      test_timeout();
      test_overflow();
      test_reset_clears();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ccip_avmm_mmio_v2.md
Name: ccip_avmm_mmio_v2

Overview:
Parametrised CCI-P MMIO to Avalon-MM master bridge, successor to the single-slot MMIO bridge in BBB_ccip_avmm.
- Accepts c0 MMIO read/write requests, excluding up to two bypass windows reserved for MPF/DFH.
- Queues requests in a command FIFO so that avmm_waitrequest never drops a command.
- Tracks outstanding read TIDs and returns c2 responses in order.
- Converts lost reads into all-ones error responses after a programmable timeout.

Parameters:
ADDR_WIDTH, 18, Avalon byte address width; MMIO dword address is zero-extended by 2 bits.
CMD_FIFO_DEPTH, 16, command FIFO entries; power of 2, at least 4.
MAX_OUTSTANDING_RD, 64, TID tracker depth and limit on reads in flight; power of 2.
BYPASS0_ADDR, 0, byte base of bypass window 0; only active when BYPASS0_SIZE is nonzero.
BYPASS0_SIZE, 0, byte size of window 0; 0 disables it.
BYPASS1_ADDR, 0, byte base of bypass window 1.
BYPASS1_SIZE, 0, byte size of window 1; 0 disables it.
RD_TIMEOUT, 4096, cycles the oldest read may wait for data; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ccip_c0_Rx_port  in  t_if_ccip_c0_Rx  CCI-P c0 receive (MMIO requests)
ccip_c2_Tx_port  out  t_if_ccip_c2_Tx  CCI-P MMIO read response
avmm_address  out  ADDR_WIDTH  byte address, 8-byte aligned
avmm_writedata  out  64  write data
avmm_byteenable  out  8  byte lanes
avmm_write  out  1  write strobe
avmm_read  out  1  read strobe
avmm_waitrequest  in  1  slave stall
avmm_readdata  in  64  read data
avmm_readdatavalid  in  1  read data valid
err_cmd_overflow  out  1  sticky; command arrived while command FIFO full
err_timeout_cnt  out  16  saturating count of timed-out reads

Behaviour:
- Reset values: all strobes 0; ccip_c2_Tx_port.mmioRdValid 0; err_cmd_overflow 0; err_timeout_cnt 0; both FIFOs empty; drop counter 0.
- Accept: mmioRdValid|mmioWrValid with address outside every enabled window -> pushed into command FIFO at cycle N+1. Bypassed requests are ignored completely: no push, no TID entry.
- 32-bit commands (length==0):
  - byteenable is 0x0F when addr[2]==0, 0xF0 when addr[2]==1.
  - write data is replicated into both halves.
  - the tracker entry stores the high-word flag.
- 64-bit commands: byteenable 0xFF.
- Issue: head of the command FIFO drives avmm_* combinationally from FIFO output. The strobe stays high while avmm_waitrequest=1. The FIFO pops on strobe & !waitrequest. Earliest strobe is cycle N+2.
- Read throttle: a read at the head is not issued while outstanding == MAX_OUTSTANDING_RD. Writes behind it wait, so ordering is strict.
- Overflow: a push while full discards the command and sets err_cmd_overflow until reset.
- TID tracker: FIFO of {hi_flag, tid, age}. Entry pushed on read acceptance into the command FIFO; popped on its response.
- Response: readdatavalid at cycle M -> c2 mmioRdValid=1 at M+1.
  - hdr.tid comes from the tracker head.
  - data[31:0] = hi_flag ? readdata[63:32] : readdata[31:0]; data[63:32] = readdata[63:32].
- Timeout: an age counter runs for the tracker head only after that read has issued, and resets on every pop.
  - When age reaches RD_TIMEOUT: emit response with data=64'hFFFF_FFFF_FFFF_FFFF and the head tid, pop the entry, increment the drop counter, increment err_timeout_cnt (saturates at 0xFFFF).
- Late data: readdatavalid while drop counter > 0 -> discarded and drop counter decremented; no c2 response.
- Simultaneous timeout and readdatavalid in the same cycle with drop counter == 0: the data wins, no timeout.
- The c2 response stream must never produce two responses in one cycle; at most one pop per cycle.
- Reset mid-operation: all queues are flushed and outstanding responses are lost. The host is responsible for not resetting with reads pending.

Decomposition:
- ccip_avmm_pkg gains t_ccip_avmm_mmio_rd_track {hi_flag, tid, age}, function in_bypass_window(), and constant CCIP_AVMM_MMIO_ERR_DATA = all-ones.
- t_ccip_avmm_mmio_cmd is reused.
- One sub-module: ccip_avmm_sync_fifo (parametrised WIDTH/DEPTH, show-ahead, synchronous reset, full/empty/usedw), instantiated twice.

Test Plan:
- 64-bit read addr 0x0010, tid=0x1A, readdata=0x1122334455667788 after 3 cycles -> avmm_address=0x40, byteenable 0xFF; c2 tid=0x1A, data=0x1122334455667788, one cycle after readdatavalid.
- 32-bit read dword address 0x0005, readdata=0xAAAABBBBCCCCDDDD -> byteenable 0xF0; c2 data[31:0]=0xAAAABBBB.
- Back-to-back writes 0x8, 0x10, 0x18 with waitrequest high for 5 cycles -> all three writes issue in order and err_cmd_overflow stays 0.
- BYPASS0_ADDR=0x1000, SIZE=0x100; read dword address 0x0400 -> no avmm_read, no c2 response. Read dword address 0x0440 -> normal response.
- RD_TIMEOUT=16, read with no readdatavalid -> c2 response at age 16 with all-ones data and err_timeout_cnt=1. Late readdatavalid is then dropped, and the next read is answered correctly.
- CMD_FIFO_DEPTH=4, waitrequest held high, 6 writes -> 4 queued and issued after release; err_cmd_overflow=1.
